// File: rtl/crosshair_pos_ctrl.sv
// Frame-synchronous crosshair position controller: samples the buttons on each
// frame_start pulse and moves a clamped coordinate pair, accelerating after a hold.
module crosshair_pos_ctrl #(
    parameter int X_MIN       = 144,
    parameter int X_MAX       = 783,
    parameter int Y_MIN       = 35,
    parameter int Y_MAX       = 514,
    parameter int X_CENTER    = 463,
    parameter int Y_CENTER    = 274,
    parameter int STEP        = 1,
    parameter int FAST_STEP   = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    output logic [9:0] cross_x,
    output logic [9:0] cross_y,
    output logic       pos_updated,
    output logic       fast_mode
);
    // state | meaning
    // IDLE  | no direction held on the last evaluated frame
    // SLOW  | direction held, moving by STEP, counting held frames
    // FAST  | held for more than HOLD_FRAMES frames, moving by FAST_STEP
    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [10:0]      X_MIN_L  = 11'(X_MIN);
    localparam logic [10:0]      X_MAX_L  = 11'(X_MAX);
    localparam logic [10:0]      Y_MIN_L  = 11'(Y_MIN);
    localparam logic [10:0]      Y_MAX_L  = 11'(Y_MAX);
    localparam logic [10:0]      STEP_L   = 11'(STEP);
    localparam logic [10:0]      FSTEP_L  = 11'(FAST_STEP);
    localparam logic [9:0]       X_CTR_L  = 10'(X_CENTER);
    localparam logic [9:0]       Y_CTR_L  = 10'(Y_CENTER);
    localparam logic [CNT_W-1:0] HOLD_L   = CNT_W'(HOLD_FRAMES);

    state_t             state;
    logic [CNT_W-1:0]   hold_cnt;
    logic               held;
    logic               go_fast;
    logic [10:0]        step;
    logic [9:0]         next_x;
    logic [9:0]         next_y;

    // Arithmetic is done one bit wider so pos+step can never wrap before the clamp.
    function automatic logic [9:0] move_axis(input logic [9:0]  pos,
                                             input logic        inc,
                                             input logic        dec,
                                             input logic [10:0] stp,
                                             input logic [10:0] lo,
                                             input logic [10:0] hi);
        logic [10:0] p;
        logic [10:0] sum;
        logic [10:0] diff;
        p    = {1'b0, pos};
        sum  = p + stp;
        diff = p - stp;
        if (inc)
            return (sum > hi) ? hi[9:0] : sum[9:0];
        if (dec)
            return (p < lo + stp) ? lo[9:0] : diff[9:0];
        return pos;
    endfunction

    always_comb begin
        held    = (btn_right ^ btn_left) | (btn_down ^ btn_up);
        go_fast = (state == FAST) || (state == SLOW && hold_cnt >= HOLD_L);
        step    = go_fast ? FSTEP_L : STEP_L;
        next_x  = move_axis(cross_x, btn_right & ~btn_left, btn_left & ~btn_right,
                            step, X_MIN_L, X_MAX_L);
        next_y  = move_axis(cross_y, btn_down & ~btn_up, btn_up & ~btn_down,
                            step, Y_MIN_L, Y_MAX_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cross_x     <= X_CTR_L;
            cross_y     <= Y_CTR_L;
            state       <= IDLE;
            hold_cnt    <= '0;
            pos_updated <= 1'b0;
            fast_mode   <= 1'b0;
        end else begin
            pos_updated <= 1'b0;
            if (frame_start) begin
                if (btn_center) begin
                    cross_x     <= X_CTR_L;
                    cross_y     <= Y_CTR_L;
                    pos_updated <= (cross_x != X_CTR_L) || (cross_y != Y_CTR_L);
                    state       <= IDLE;
                    hold_cnt    <= '0;
                    fast_mode   <= 1'b0;
                end else if (!held) begin
                    state     <= IDLE;
                    hold_cnt  <= '0;
                    fast_mode <= 1'b0;
                end else begin
                    cross_x     <= next_x;
                    cross_y     <= next_y;
                    pos_updated <= (next_x != cross_x) || (next_y != cross_y);
                    if (state == IDLE) begin
                        state     <= SLOW;
                        hold_cnt  <= CNT_W'(1);
                        fast_mode <= 1'b0;
                    end else if (go_fast) begin
                        state     <= FAST;
                        fast_mode <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + 1'b1;
                        fast_mode <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_crosshair_pos_ctrl.sv
// Self-checking bench for crosshair_pos_ctrl: table vectors, corner sequences and
// randomized frames against a behavioural model.
module tb_crosshair_pos_ctrl;
    localparam int HOLD = 3;
    localparam int XMIN = 144, XMAX = 783, YMIN = 35, YMAX = 514;
    localparam int XC = 463, YC = 274;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_center = 1'b0;
    logic [9:0] cross_x, cross_y;
    logic       pos_updated, fast_mode;

    int tests = 0;
    int fails = 0;

    // Model: mode 0 = idle, 1 = slow, 2 = fast
    int mx = XC, my = YC, mmode = 0, mcnt = 0;
    bit mupd = 0;

    typedef struct {
        logic [4:0] b;
        int         x;
        int         y;
        bit         upd;
        bit         fast;
    } vec_t;
    vec_t tbl[$];

    crosshair_pos_ctrl #(.HOLD_FRAMES(HOLD), .STEP(1), .FAST_STEP(4)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_center(btn_center),
        .cross_x(cross_x), .cross_y(cross_y),
        .pos_updated(pos_updated), .fast_mode(fast_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // b = {center, up, down, left, right}
    task automatic drive(input logic [4:0] b);
        {btn_center, btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_frame(input logic [4:0] b);
        int ox, oy, dx, dy, st;
        ox = mx; oy = my;
        dx = int'(b[0]) - int'(b[1]);
        dy = int'(b[2]) - int'(b[3]);
        if (b[4]) begin
            mx = XC; my = YC; mmode = 0; mcnt = 0;
        end else if (dx == 0 && dy == 0) begin
            mmode = 0; mcnt = 0;
        end else begin
            if (mmode == 0) begin
                mmode = 1; mcnt = 1; st = 1;
            end else if (mmode == 1 && mcnt < HOLD) begin
                mcnt++; st = 1;
            end else begin
                mmode = 2; st = 4;
            end
            mx = clampi(mx + dx * st, XMIN, XMAX);
            my = clampi(my + dy * st, YMIN, YMAX);
        end
        mupd = (mx != ox) || (my != oy);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".x"}, int'(cross_x), mx);
        chk({tag, ".y"}, int'(cross_y), my);
        chk({tag, ".upd"}, int'(pos_updated), int'(mupd));
        chk({tag, ".fast"}, int'(fast_mode), int'(mmode == 2));
    endtask

    // Gap cycles carry noise buttons that must have no effect; then one pulse with b.
    task automatic frame(input logic [4:0] b, input logic [4:0] noise, input int gap);
        for (int i = 0; i < gap; i++) begin
            drive(noise);
            tick();
            tests++;
            if (int'(cross_x) != mx || int'(cross_y) != my || pos_updated !== 1'b0
                || int'(fast_mode) != int'(mmode == 2)) begin
                fails++;
                $display("FAIL stable: got x=%0d y=%0d upd=%0b fast=%0b, expected x=%0d y=%0d upd=0 fast=%0b",
                         cross_x, cross_y, pos_updated, fast_mode, mx, my, mmode == 2);
            end
        end
        drive(b);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_frame(b);
    endtask

    task automatic do_reset(input int n, input logic fs);
        rst = 1'b1;
        frame_start = fs;
        drive(5'b00001);
        repeat (n) tick();
        rst = 1'b0;
        frame_start = 1'b0;
        mx = XC; my = YC; mmode = 0; mcnt = 0; mupd = 0;
        chk("reset.x", int'(cross_x), XC);
        chk("reset.y", int'(cross_y), YC);
        chk("reset.upd", int'(pos_updated), 0);
        chk("reset.fast", int'(fast_mode), 0);
    endtask

    task automatic add(input logic [4:0] b, input int x, input int y, input bit u, input bit f);
        vec_t v;
        v.b = b; v.x = x; v.y = y; v.upd = u; v.fast = f;
        tbl.push_back(v);
    endtask

    initial begin
        logic [4:0] dir;
        logic [4:0] b;
        int         gap;

        // Acceleration, release, opposite+diagonal, center
        for (int i = 0; i < 6; i++)
            add(5'b00001, 464 + ((i < 3) ? i : 2 + 4 * (i - 2)), 274, 1, i >= 3);
        add(5'b00000, 478, 274, 0, 0);
        add(5'b00111, 478, 275, 1, 0);
        add(5'b00111, 478, 276, 1, 0);
        add(5'b00111, 478, 277, 1, 0);
        add(5'b00111, 478, 281, 1, 1);
        add(5'b00011, 478, 281, 0, 0);
        add(5'b10000, 463, 274, 1, 0);
        add(5'b10000, 463, 274, 0, 0);

        tick();
        do_reset(2, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            frame(tbl[i].b, 5'b00000, 19);
            chk($sformatf("vec%0d.x", i), int'(cross_x), tbl[i].x);
            chk($sformatf("vec%0d.y", i), int'(cross_y), tbl[i].y);
            chk($sformatf("vec%0d.upd", i), int'(pos_updated), int'(tbl[i].upd));
            chk($sformatf("vec%0d.fast", i), int'(fast_mode), int'(tbl[i].fast));
            tick();
            chk($sformatf("vec%0d.upd_pulse", i), int'(pos_updated), 0);
        end

        // Clamp at Y_MIN: arrange y=37 while in FAST, then push up
        for (int i = 0; i < 2; i++) frame(5'b01000, 5'b00000, 19);
        frame(5'b00000, 5'b00000, 19);
        for (int i = 0; i < 61; i++) frame(5'b01000, 5'b00000, 19);
        chk("yclamp.pre_y", int'(cross_y), 37);
        chk("yclamp.pre_fast", int'(fast_mode), 1);
        frame(5'b01000, 5'b00000, 19);
        chk("yclamp.y", int'(cross_y), 35);
        chk("yclamp.upd", int'(pos_updated), 1);
        frame(5'b01000, 5'b00000, 19);
        chk("yclamp.hold_y", int'(cross_y), 35);
        chk("yclamp.hold_upd", int'(pos_updated), 0);

        // Clamp at X_MAX: arrange x=781 while in FAST, then push right
        do_reset(1, 1'b0);
        for (int i = 0; i < 3; i++) frame(5'b00001, 5'b00000, 19);
        frame(5'b00000, 5'b00000, 19);
        for (int i = 0; i < 81; i++) frame(5'b00001, 5'b00000, 19);
        chk("xclamp.pre_x", int'(cross_x), 781);
        frame(5'b00001, 5'b00000, 19);
        chk("xclamp.x", int'(cross_x), 783);
        chk("xclamp.upd", int'(pos_updated), 1);
        frame(5'b00001, 5'b00000, 19);
        chk("xclamp.hold_x", int'(cross_x), 783);
        chk("xclamp.hold_upd", int'(pos_updated), 0);

        // Center wins over a held direction in FAST
        frame(5'b10001, 5'b00000, 19);
        chk("center.x", int'(cross_x), 463);
        chk("center.y", int'(cross_y), 274);
        chk("center.fast", int'(fast_mode), 0);
        chk("center.upd", int'(pos_updated), 1);

        // Button activity between pulses must be ignored
        for (int i = 0; i < 3; i++) begin
            frame(5'b00000, 5'(i + 1), 19);
            chk("noise.x", int'(cross_x), 463);
            chk("noise.y", int'(cross_y), 274);
            chk("noise.upd", int'(pos_updated), 0);
        end

        // Reset mid-FAST, then a pulse right after release restarts in SLOW
        for (int i = 0; i < 4; i++) frame(5'b00001, 5'b00000, 19);
        chk("rstfast.pre_fast", int'(fast_mode), 1);
        do_reset(1, 1'b1);
        frame(5'b00001, 5'b00000, 0);
        chk("rstfast.x", int'(cross_x), 464);
        chk("rstfast.fast", int'(fast_mode), 0);
        chk("rstfast.upd", int'(pos_updated), 1);

        // Randomized frames against the model
        dir = 5'b00001;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset($urandom_range(1, 2), 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 9) == 0) dir = 5'($urandom_range(0, 15));
                b = ($urandom_range(0, 29) == 0) ? 5'b10000 | 5'($urandom_range(0, 15)) : dir;
                gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 19);
                frame(b, 5'($urandom), gap);
                chk_model($sformatf("rand%0d", n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/crosshair_pos_ctrl.md
# crosshair_pos_ctrl

Frame-synchronous position controller for the VGA crosshair overlay. It samples five level buttons (up/down/left/right/center) once per frame and moves a crosshair coordinate pair inside the visible window. Movement accelerates from a slow step to a fast step while a direction is held. It sits between the board button synchronisers and the pixel-colour logic of the VGA sync block, and runs on the 25 MHz pixel clock. Its registered `cross_x`/`cross_y` replace the constant crosshair column/row compares.

## Interface
- `X_MIN`, 144: first visible column (counter value).
- `X_MAX`, 783: last visible column.
- `Y_MIN`, 35: first visible row.
- `Y_MAX`, 514: last visible row.
- `X_CENTER`, 463: reset/center column.
- `Y_CENTER`, 274: reset/center row.
- `STEP`, 1: pixels per frame in slow mode.
- `FAST_STEP`, 4: pixels per frame in fast mode.
- `HOLD_FRAMES`, 30: held frames before fast mode (≥1).
- `clk`  in  1  pixel clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse at h=0, v=0 from the sync timing.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_center`  in  1 each  synchronised, active-high levels.
- `cross_x`  out  10  crosshair column, registered.
- `cross_y`  out  10  crosshair row, registered.
- `pos_updated`  out  1  one-cycle pulse when `cross_x` or `cross_y` changed.
- `fast_mode`  out  1  high while the FSM is in FAST.

## Operation
- **Sampling.** Buttons are sampled only in cycles where `frame_start`=1. Button activity between pulses is ignored, which gives 60 Hz natural debounce.
- **Axis deltas.**
  - `dx` = right − left. `dy` = down − up.
  - Opposite buttons pressed together give a delta of 0 on that axis.
  - "Held" means `dx`≠0 or `dy`≠0.
- **FSM states:** IDLE, SLOW, FAST. The frame counter `hold_cnt` saturates at `HOLD_FRAMES`.
- **Transitions.** Evaluated only on `frame_start`; priority order is top to bottom.
  - `btn_center`=1, any state:
    - Positions load `X_CENTER`/`Y_CENTER`.
    - FSM → IDLE, `hold_cnt`=0.
    - Direction buttons are ignored that frame.
  - Not held, any state: → IDLE, `hold_cnt`=0, no move.
  - IDLE and held: → SLOW, `hold_cnt`=1, move by `STEP`.
  - SLOW, held, `hold_cnt`<`HOLD_FRAMES`: stay in SLOW, `hold_cnt`++, move by `STEP`.
  - SLOW, held, `hold_cnt`=`HOLD_FRAMES`: → FAST, move by `FAST_STEP`.
  - FAST, held: stay in FAST, move by `FAST_STEP`.
  - Changing direction while still held does not leave SLOW/FAST.
- **Move arithmetic.** Computed at 11 bits unsigned, then clamped per axis.
  - Increment: `pos+step > MAX` → `MAX`.
  - Decrement: `pos < MIN+step` → `MIN`.
  - Otherwise `pos ± step`.
  - No wrap-around, ever. Both axes move in the same frame for diagonal holds.
- **`pos_updated`.** Asserted for exactly one cycle when a frame evaluation changes either coordinate. It stays low when a clamp or center leaves the values unchanged.

## Timing
- **Reset** (`rst`=1 at a clock edge), with priority over `frame_start`:
  - `cross_x`=`X_CENTER`, `cross_y`=`Y_CENTER`.
  - FSM=IDLE, `hold_cnt`=0.
  - `pos_updated`=0, `fast_mode`=0.
- **Latency.** `frame_start` sampled high at edge N gives new `cross_x`/`cross_y`, `pos_updated` and `fast_mode` visible after edge N. They are stable for the rest of the frame, so there is no mid-frame tearing because h=0, v=0 is in blanking.
- **Back-to-back pulses.** Consecutive `frame_start` cycles are each a full evaluation; nothing is dropped.
- **Reset mid-hold.** Returns to center and IDLE. The next held frame counts as frame 1 (SLOW).
- **Output stability.** Outputs never change in cycles without `frame_start` or `rst`.

## Test plan
Bench uses `HOLD_FRAMES`=3, `STEP`=1, `FAST_STEP`=4, defaults otherwise, with `frame_start` pulsed every 20 cycles.

1. **Reset.** Assert `rst` 2 cycles → `cross_x`=463, `cross_y`=274, `pos_updated`=0, `fast_mode`=0.
2. **Acceleration.** Hold `btn_right` for 6 frames → `cross_x` sequence 464, 465, 466, 470, 474, 478. `fast_mode` rises after frame 4. Each change comes with a 1-cycle `pos_updated` pulse one cycle after `frame_start`. Release, then 1 frame → IDLE, `fast_mode`=0, x stays 478.
3. **Clamp.** Start at `cross_y`=37 in FAST (press `btn_up`) → y=35 and stays 35 on further frames, with `pos_updated` low once clamped. Repeat at `X_MAX`: x=781 with FAST right → 783.
4. **Opposite and diagonal.** `btn_left`+`btn_right`+`btn_down` held → x unchanged, y+1 per SLOW frame.
5. **Center priority.** Center with direction held in FAST → position 463/274, IDLE. Buttons toggled between `frame_start` pulses produce no change.
6. **Reset mid-FAST.** Sync reset in FAST → center and IDLE. The next held frame moves by 1 (SLOW) even if `frame_start` coincides with the `rst` release cycle+1.
